// File: rtl/sdp_bram_pkg.sv
// Shared types and constants for the SDP BRAM stream reader.
// Used by sdp_bram_stream_reader and bram_rd_skid.
package sdp_bram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int SKID_DEPTH = 2;

    // Remaining-word counter must hold 2**aw, hence one extra bit.
    function automatic int len_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry skid buffer that absorbs the one-cycle BRAM read latency.
// Entry 0 is always the head; a pop shifts the entries down by one.
module bram_rd_skid
    import sdp_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] entry_reg     [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] entry_shifted [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] entry_next    [SKID_DEPTH];
    logic [1:0]            count_reg;
    logic [1:0]            count_next;
    logic [1:0]            base_count;
    logic                  pop_ok;
    logic                  push_ok;

    assign pop_ok     = pop && (count_reg != 2'd0);
    assign base_count = pop_ok ? count_reg - 2'd1 : count_reg;
    // A push into a full buffer without a pop is dropped; the credit rule upstream prevents it.
    assign push_ok    = push && (base_count < 2'(SKID_DEPTH));
    assign count_next = base_count + {1'b0, push_ok};

    genvar gi;
    generate
        for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
            if (gi < SKID_DEPTH - 1) begin : g_shift
                assign entry_shifted[gi] = pop_ok ? entry_reg[gi+1] : entry_reg[gi];
            end else begin : g_hold
                assign entry_shifted[gi] = entry_reg[gi];
            end

            assign entry_next[gi] = (push_ok && (base_count == 2'(gi))) ? data_in
                                                                        : entry_shifted[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg[gi] <= '0;
                end else begin
                    entry_reg[gi] <= entry_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 2'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign head  = entry_reg[0];

endmodule

// File: rtl/sdp_bram_stream_reader.sv
// Burst read master for a 1-cycle-latency SDP BRAM, presenting words as a valid/ready stream.
// Optional out_last port enabled by defining SDP_BRAM_STREAM_READER_LAST_EN.
module sdp_bram_stream_reader
    import sdp_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic [ADDR_WIDTH-1:0] ra,
    output logic                  re,
    input  logic [DATA_WIDTH-1:0] rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
`ifdef SDP_BRAM_STREAM_READER_LAST_EN
    output logic                  out_last,
`endif
    output logic                  done
);

    localparam int LW = len_width(ADDR_WIDTH);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_DRAIN = 2'(DRAIN);

`ifdef SDP_BRAM_STREAM_READER_LAST_EN
    localparam int EW = DATA_WIDTH + 1;
`else
    localparam int EW = DATA_WIDTH;
`endif

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [ADDR_WIDTH-1:0] ra_reg;
    logic [ADDR_WIDTH-1:0] ra_next;
    logic [LW-1:0]         rem_reg;
    logic [LW-1:0]         rem_next;
    logic                  inflight_reg;
    logic                  re_c;
    logic                  done_c;
    logic                  pop;
    logic                  credit_ok;
    logic [1:0]            buf_count;
    logic [1:0]            occupancy;
    logic [EW-1:0]         skid_in;
    logic [EW-1:0]         skid_head;

    assign pop       = out_valid && out_ready;
    // Reads in flight count against buffer space until their data lands.
    assign occupancy = buf_count + {1'b0, inflight_reg};
    assign credit_ok = (occupancy < 2'(SKID_DEPTH)) ||
                       ((occupancy == 2'(SKID_DEPTH)) && pop);

    always_comb begin
        state_next = state_reg;
        ra_next    = ra_reg;
        rem_next   = rem_reg;
        re_c       = 1'b0;
        done_c     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    ra_next    = cmd_addr;
                    rem_next   = LW'({1'b0, cmd_len}) + LW'(1);
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (credit_ok) begin
                    re_c     = 1'b1;
                    ra_next  = ra_reg + ADDR_WIDTH'(1);
                    rem_next = rem_reg - LW'(1);
                    if (rem_reg == LW'(1)) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && (buf_count == 2'd1) && !inflight_reg) begin
                    done_c     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            ra_reg       <= '0;
            rem_reg      <= '0;
            inflight_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ra_reg       <= ra_next;
            rem_reg      <= rem_next;
            inflight_reg <= re_c;
        end
    end

`ifdef SDP_BRAM_STREAM_READER_LAST_EN
    logic inflight_last_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_last_reg <= 1'b0;
        end else begin
            inflight_last_reg <= re_c && (rem_reg == LW'(1));
        end
    end

    assign skid_in  = {inflight_last_reg, rd};
    assign out_last = out_valid && skid_head[DATA_WIDTH];
`else
    assign skid_in  = rd;
`endif

    bram_rd_skid #(
        .DATA_WIDTH (EW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push    (inflight_reg),
        .data_in (skid_in),
        .pop     (pop),
        .count   (buf_count),
        .head    (skid_head)
    );

    assign cmd_ready = (state_reg == S_IDLE);
    assign ra        = ra_reg;
    assign re        = re_c;
    assign out_valid = (buf_count != 2'd0);
    assign out_data  = skid_head[DATA_WIDTH-1:0];
    assign done      = done_c;

endmodule

// File: tb/tb_sdp_bram_stream_reader.sv
// Scoreboard bench for sdp_bram_stream_reader with a behavioural 1-cycle-latency BRAM.
module tb_sdp_bram_stream_reader;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic [AW-1:0] ra;
    logic          re;
    logic [DW-1:0] rd = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          done;
`ifdef SDP_BRAM_STREAM_READER_LAST_EN
    logic          out_last;
`endif

    sdp_bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ra        (ra),
        .re        (re),
        .rd        (rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SDP_BRAM_STREAM_READER_LAST_EN
        .out_last  (out_last),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [1<<AW];
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 3);
    always @(posedge clk) if (re) rd <= mem[ra];

    logic [DW-1:0] exp_data_q [$];
    bit            exp_last_q [$];
    logic [AW-1:0] exp_addr_q [$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int done_cnt = 0;
    int tb_occ = 0;
    int pops_in_burst = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit bp_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Backpressure pattern 1,0,0,1 when enabled, otherwise always ready.
    initial begin
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = (phase == 0) || (phase == 3);
                phase = (phase + 1) % 4;
            end else begin
                out_ready = 1'b1;
                phase = 0;
            end
        end
    end

    // Monitor: compares every issued read and every popped word against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            bit pop;
            pop = out_valid && out_ready;
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", out_data, prev_data);
            end
            if (re) begin
                check("credit_rule", ((tb_occ - int'(pop)) <= 1), 1);
                if (exp_addr_q.size() == 0) check("unexpected_read_ra", ra, 64'hFFFF);
                else check("ra", ra, exp_addr_q.pop_front());
            end
            if (pop) begin
                if (exp_data_q.size() == 0) begin
                    check("unexpected_word", out_data, 64'hFFFF_FFFF_FFFF);
                end else begin
                    logic [DW-1:0] ed;
                    bit el;
                    ed = exp_data_q.pop_front();
                    el = exp_last_q.pop_front();
                    $display("pop data=%0d expected=%0d", out_data, ed);
                    check("out_data", out_data, ed);
`ifdef SDP_BRAM_STREAM_READER_LAST_EN
                    check("out_last", out_last, el);
`endif
                end
                if (pops_in_burst == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pops_in_burst++;
            end
            if (done) begin
                done_cnt++;
                check("done_with_last_pop", (pop && exp_data_q.size() == 0), 1);
            end
            tb_occ = tb_occ + int'(re) - int'(pop);
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a command; auto_data pushes addr*3 words, otherwise the caller pushes literals.
    task automatic send_cmd(input int addr, input int len, input bit auto_data);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("cmd_ready_before_issue", cmd_ready, 1);
        pops_in_burst = 0;
        for (int k = 0; k <= len; k++) begin
            logic [AW-1:0] a;
            a = AW'(addr + k);
            exp_addr_q.push_back(a);
            if (auto_data) begin
                exp_data_q.push_back(DW'(int'(a) * 3));
                exp_last_q.push_back(k == len);
            end
        end
        cmd_addr = AW'(addr);
        cmd_len = AW'(len);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        $display("cmd addr=%0d len=%0d accepted", addr, len);
    endtask

    task automatic push_word(input int data, input bit last);
        exp_data_q.push_back(DW'(data));
        exp_last_q.push_back(last);
    endtask

    task automatic wait_done(input int limit, input int exp_words);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < limit) begin
            tick();
            n++;
        end
        check("done_before_timeout", (done_cnt != start), 1);
        check("cmd_ready_after_done", cmd_ready, 1);
        check("burst_word_count", pops_in_burst, exp_words);
        repeat (3) tick();
        check("single_done_pulse", done_cnt, start + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_re", re, 0);
        check("reset_ra", ra, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        tick();

        // Basic burst with latency checks
        push_word(15, 0); push_word(18, 0); push_word(21, 0); push_word(24, 1);
        send_cmd(5, 3, 0);
        check("first_re_after_accept", re, 1);
        check("valid_low_cycle1", out_valid, 0);
        check("cmd_ready_low_in_run", cmd_ready, 0);
        tick();
        check("valid_low_cycle2", out_valid, 0);
        tick();
        check("valid_high_2clk_after_accept", out_valid, 1);
        wait_done(100, 4);
        check("burst4_consecutive", last_pop_cyc - first_pop_cyc, 3);

        // Address wrap
        push_word(186, 0); push_word(189, 0); push_word(0, 0); push_word(3, 1);
        send_cmd(62, 3, 0);
        wait_done(100, 4);

        // Backpressure 1,0,0,1
        bp_mode = 1'b1;
        send_cmd(20, 7, 1);
        wait_done(200, 8);
        bp_mode = 1'b0;
        tick();

        // Full RAM burst, must stream at one word per clock
        send_cmd(10, 63, 1);
        wait_done(300, 64);
        check("full_burst_throughput", last_pop_cyc - first_pop_cyc, 63);

        // Commands during a burst are ignored
        send_cmd(0, 15, 1);
        tick();
        cmd_addr = AW'(40);
        cmd_len = AW'(2);
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("cmd_ready_low_busy", cmd_ready, 0);
            tick();
        end
        cmd_valid = 1'b0;
        wait_done(100, 16);

        // Single-word and short bursts (out_last when enabled)
        push_word(21, 1);
        send_cmd(7, 0, 0);
        wait_done(100, 1);
        send_cmd(33, 3, 1);
        wait_done(100, 4);

        // Reset mid-burst
        begin
            int d0;
            send_cmd(0, 31, 1);
            repeat (6) tick();
            d0 = done_cnt;
            rst = 1'b1;
            #1;
            exp_data_q.delete();
            exp_last_q.delete();
            exp_addr_q.delete();
            tb_occ = 0;
            prev_stall = 1'b0;
            check("midreset_out_valid", out_valid, 0);
            check("midreset_re", re, 0);
            check("midreset_done", done, 0);
            check("midreset_cmd_ready", cmd_ready, 1);
            repeat (2) tick();
            rst = 1'b0;
            tick();
            check("no_done_on_reset", done_cnt, d0);
        end

        push_word(90, 0); push_word(93, 1);
        send_cmd(30, 1, 0);
        wait_done(100, 2);

        check("scoreboard_empty", exp_data_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
